// File: rtl/div_ctrl_pkg.sv
// Shared FSM encoding, default sizes and arithmetic helpers for the divider sharing controller.
package div_ctrl_pkg;

    localparam int unsigned W_DEF       = 8;
    localparam int unsigned NREQ_DEF    = 4;
    localparam int unsigned DIV_LAT_DEF = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LAUNCH = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    // All-ones quotient reported for a zero divisor, right-aligned to width w (1..32).
    function automatic logic [31:0] dz_quot(input int unsigned w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

    function automatic logic [31:0] negate(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Caller passes the operand's own sign bit, so this works for any width up to 32.
    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic neg);
        return neg ? negate(v) : v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!any && req[j[IW-1:0]]) begin
                any               = 1'b1;
                grant[j[IW-1:0]]  = 1'b1;
                idx               = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider among NREQ requesters with round-robin arbitration.
// Define SIGNED_DIV_EN for two's complement operands (magnitudes to divider, signs fixed on return).
module div_share_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned W       = W_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    localparam int unsigned IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_dividend,
    input  logic [NREQ*W-1:0]   req_divisor,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IW-1:0]       rsp_id,
    output logic [W-1:0]        rsp_q,
    output logic [W-1:0]        rsp_r,
    output logic                rsp_dz,
    output logic                div_start,
    output logic [W-1:0]        div_D,
    output logic [W-1:0]        div_d,
    input  logic [W-1:0]        div_q,
    input  logic [W-1:0]        div_r,
    input  logic                div_done
);

    localparam int unsigned CW = $clog2(DIV_LAT + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   id_q, id_d;
    logic [W-1:0]    op_D_q, op_D_d;
    logic [W-1:0]    op_d_q, op_d_d;
    logic [W-1:0]    res_q_q, res_q_d;
    logic [W-1:0]    res_r_q, res_r_d;
    logic            res_dz_q, res_dz_d;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   idx;
    logic            any;
    logic [W-1:0]    sel_D, sel_d, mag_D, mag_d, fix_q, fix_r;

    // Completion is timed by the wait counter; the divider's sticky done is not trusted.
    logic unused_div_done;
    assign unused_div_done = div_done;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    assign sel_D = req_dividend[idx*W +: W];
    assign sel_d = req_divisor[idx*W +: W];

`ifdef SIGNED_DIV_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;

    // |-2^(W-1)| is 2^(W-1), which still fits W bits as an unsigned magnitude.
    assign mag_D = W'(abs_val(32'(sel_D), sel_D[W-1]));
    assign mag_d = W'(abs_val(32'(sel_d), sel_d[W-1]));
    assign fix_q = neg_q_q ? W'(negate(32'(div_q))) : div_q;
    assign fix_r = neg_r_q ? W'(negate(32'(div_r))) : div_r;

    always_comb begin
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        if (state_q == ST_IDLE && any) begin
            neg_q_d = sel_D[W-1] ^ sel_d[W-1];
            neg_r_d = sel_D[W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end
`else
    assign mag_D = sel_D;
    assign mag_d = sel_d;
    assign fix_q = div_q;
    assign fix_r = div_r;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        op_D_d   = op_D_q;
        op_d_d   = op_d_q;
        res_q_d  = res_q_q;
        res_r_d  = res_r_q;
        res_dz_d = res_dz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    ptr_d  = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
                    id_d   = idx;
                    op_D_d = mag_D;
                    op_d_d = mag_d;
                    if (sel_d == '0) begin
                        // Zero divisor bypasses the divider entirely.
                        res_q_d  = W'(dz_quot(W));
                        res_r_d  = sel_D;
                        res_dz_d = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CW'(DIV_LAT - 1)) begin
                    res_q_d  = fix_q;
                    res_r_d  = fix_r;
                    res_dz_d = 1'b0;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            op_D_q   <= '0;
            op_d_q   <= '0;
            res_q_q  <= '0;
            res_r_q  <= '0;
            res_dz_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            op_D_q   <= op_D_d;
            op_d_q   <= op_d_d;
            res_q_q  <= res_q_d;
            res_r_q  <= res_r_d;
            res_dz_q <= res_dz_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
    assign div_start = (state_q == ST_LAUNCH);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_q     = res_q_q;
    assign rsp_r     = res_r_q;
    assign rsp_dz    = res_dz_q;
    assign div_D     = op_D_q;
    assign div_d     = op_d_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl with a behavioural fixed-latency divider.
module tb_div_share_ctrl;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned W       = 8;
    localparam int unsigned DIV_LAT = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req_valid = '0;
    logic [3:0]      req_ready;
    logic [31:0]     req_dividend, req_divisor;
    logic            rsp_valid, rsp_ready, rsp_dz;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_q, rsp_r;
    logic            div_start;
    logic [7:0]      div_D, div_d;
    logic [7:0]      div_q_m = 8'h00, div_r_m = 8'h00;
    logic            div_done_m = 1'b0;

    logic [7:0]      op_D [4];
    logic [7:0]      op_d [4];

    assign req_dividend = {op_D[3], op_D[2], op_D[1], op_D[0]};
    assign req_divisor  = {op_d[3], op_d[2], op_d[1], op_d[0]};

    div_share_ctrl #(
        .NREQ    (NREQ),
        .W       (W),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_q        (rsp_q),
        .rsp_r        (rsp_r),
        .rsp_dz       (rsp_dz),
        .div_start    (div_start),
        .div_D        (div_D),
        .div_d        (div_d),
        .div_q        (div_q_m),
        .div_r        (div_r_m),
        .div_done     (div_done_m)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  id;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        int unsigned acc;
        int unsigned lat;
    } rsp_t;

    rsp_t        sb[$];
    logic [15:0] launch_q[$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Divider model: results are junk until DIV_LAT cycles after the start pulse.
    logic       div_busy = 1'b0;
    int         div_k = 0;
    logic [7:0] m_D = 8'h00, m_d = 8'h01;
    always @(posedge clk) begin
        if (div_start) begin
            div_busy   <= 1'b1;
            div_k      <= 0;
            div_q_m    <= 8'hA5;
            div_r_m    <= 8'h5A;
            div_done_m <= 1'b0;
            m_D        <= div_D;
            m_d        <= div_d;
        end else if (div_busy) begin
            div_k <= div_k + 1;
            if (div_k == int'(DIV_LAT) - 2) begin
                div_busy   <= 1'b0;
                div_done_m <= 1'b1;
                div_q_m    <= m_D / m_d;
                div_r_m    <= m_D % m_d;
            end
        end
    end

    initial begin : monitor
        bit   in_rsp = 1'b0;
        rsp_t e;
        logic [15:0] l;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                in_rsp = 1'b0;
                continue;
            end
            if (div_start) begin
                if (launch_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL div_start: got unexpected launch D=0x%0h d=0x%0h, expected none",
                             div_D, div_d);
                end else begin
                    l = launch_q.pop_front();
                    check("div_D", 32'(div_D), 32'(l[15:8]));
                    check("div_d", 32'(div_d), 32'(l[7:0]));
                end
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got rsp id=%0d q=0x%0h, expected none",
                             rsp_id, rsp_q);
                end else begin
                    e = sb[0];
                    if (!in_rsp) begin
                        check("rsp_latency", cyc + 1 - e.acc, e.lat);
                        in_rsp = 1'b1;
                    end
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_q", 32'(rsp_q), 32'(e.q));
                    check("rsp_r", 32'(rsp_r), 32'(e.r));
                    check("rsp_dz", 32'(rsp_dz), 32'(e.dz));
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        in_rsp = 1'b0;
                    end
                end
            end
        end
    end

    // Waits for a grant, checks it is one-hot on id and queues the expected response/launch.
    task automatic grant(input int id, input logic [7:0] q, input logic [7:0] r, input logic dz,
                         input logic [7:0] mD, input logic [7:0] md);
        int t = 0;
        #1;
        while (req_ready == '0 && t < 60) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (req_ready == '0) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: got req_ready=0, expected grant to %0d", id);
            return;
        end
        check("req_ready", 32'(req_ready), 32'(1) << id);
        sb.push_back('{id: 2'(id), q: q, r: r, dz: dz, acc: cyc + 1,
                       lat: dz ? 1 : DIV_LAT + 2});
        if (!dz) launch_q.push_back({mD, md});
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_one(input int id, input logic [7:0] D, input logic [7:0] d,
                           input logic [7:0] q, input logic [7:0] r, input logic dz,
                           input logic [7:0] mD, input logic [7:0] md);
        op_D[id]  = D;
        op_d[id]  = d;
        req_valid = 4'(1 << id);
        grant(id, q, r, dz, mD, md);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_drain();
    endtask

    // Small positive operands, identical in signed and unsigned builds.
    task automatic load_arb_ops();
        op_D[0] = 8'd20; op_d[0] = 8'd3;
        op_D[1] = 8'd21; op_d[1] = 8'd4;
        op_D[2] = 8'd22; op_d[2] = 8'd5;
        op_D[3] = 8'd23; op_d[3] = 8'd6;
    endtask

    logic [7:0] arb_q [4];
    logic [7:0] arb_r [4];

    initial begin
        int t;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_D[i] = '0;
            op_d[i] = 8'd1;
        end
        arb_q[0] = 8'd6; arb_r[0] = 8'd2;
        arb_q[1] = 8'd5; arb_r[1] = 8'd1;
        arb_q[2] = 8'd4; arb_r[2] = 8'd2;
        arb_q[3] = 8'd3; arb_r[3] = 8'd5;

        repeat (3) @(negedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_q", 32'(rsp_q), 0);
        check("reset_rsp_r", 32'(rsp_r), 0);
        check("reset_rsp_dz", 32'(rsp_dz), 0);
        check("reset_div_start", 32'(div_start), 0);
        check("reset_div_D", 32'(div_D), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef SIGNED_DIV_EN
        run_one(0, 8'd200, 8'd7, 8'hF8, 8'h00, 1'b0, 8'h38, 8'h07);    // -56 / 7
        run_one(1, 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 8'h00, 8'h00);
        run_one(2, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 8'h07, 8'h02);
        run_one(3, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 8'h07, 8'h02);
        run_one(0, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8'h80, 8'h01);
`else
        run_one(0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8'd200, 8'd7);
        run_one(1, 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 8'h00, 8'h00);
        run_one(2, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 8'hFF, 8'h10);
        run_one(3, 8'h09, 8'h0A, 8'h00, 8'h09, 1'b0, 8'h09, 8'h0A);
        run_one(0, 8'h64, 8'h01, 8'h64, 8'h00, 1'b0, 8'h64, 8'h01);
`endif

        // Reset while the wait counter sits at 4; the in-flight result must vanish.
        load_arb_ops();
        req_valid = 4'b0001;
        grant(0, arb_q[0], arb_r[0], 1'b0, 8'd20, 8'd3);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_q", 32'(rsp_q), 0);
        check("rst_div_D", 32'(div_D), 0);
        repeat (DIV_LAT + 5) @(negedge clk);

        // Continuous requests from all four: pointer restarts at 0 after reset.
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            grant(k % 4, arb_q[k % 4], arb_r[k % 4], 1'b0, op_D[k % 4], op_d[k % 4]);
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = '0;
        wait_drain();

        // Pointer now 1: lone req2 wins, then lone req2 again with pointer 3.
        run_one(2, 8'd22, 8'd5, 8'd4, 8'd2, 1'b0, 8'd22, 8'd5);
        run_one(2, 8'd22, 8'd5, 8'd4, 8'd2, 1'b0, 8'd22, 8'd5);

        // Backpressure: response must hold and no grants issue while stalled.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        grant(1, arb_q[1], arb_r[1], 1'b0, 8'd21, 8'd4);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b1101;
        t = 0;
        while (!rsp_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("stall_rsp_seen", 32'(rsp_valid), 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            check("stall_req_ready", 32'(req_ready), 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = '0;
        wait_drain();
        repeat (DIV_LAT) @(negedge clk);
        check("launch_queue_empty", 32'(launch_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
